mem_arbiter: RTL and testbench

Sequencing controller that shares the single Hack data-memory port (RAM16K, screen RAM8K, keyboard register) between the CPU data path and a read-only screen-scan DMA requester. Each cycle it performs exactly one memory access: a single CPU read/write, or one beat of a fixed-length DMA read burst with auto-incrementing addresses. CPU has priority; a starvation counter guarantees the DMA port a burst after a bounded wait. It sits between the CPU (`outM`/`writeM`/`addressM`/`inM`) and the Memory block inside the computer top level.

---
 rtl/mem_arbiter.sv | 82 ++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single Hack data-memory port between CPU accesses and fixed-length DMA read bursts.
//   clock, reset          : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata : CPU access request; cpu_gnt is the same-cycle grant
//   cpu_rdata/cpu_rvalid  : registered CPU read return, one cycle after the access
//   dma_req/dma_addr      : burst request and start address; dma_gnt pulses on the first beat
//   dma_rdata/rvalid/done : registered burst read return; done marks the last word
//   mem_in/load/address   : Memory write data, write enable, address; mem_out is Memory read data
module mem_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int BURST = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [14:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_gnt,
   output logic [15:0] cpu_rdata,
   output logic        cpu_rvalid,
   input  logic        dma_req,
   input  logic [14:0] dma_addr,
   output logic        dma_gnt,
   output logic [15:0] dma_rdata,
   output logic        dma_rvalid,
   output logic        dma_done,
   output logic [15:0] mem_in,
   output logic        mem_load,
   output logic [14:0] mem_address,
   input  logic [15:0] mem_out
);
   localparam int BW = $clog2(BURST);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic IDLE = 1'b0;
   localparam logic BRST = 1'b1;
   logic state;
   logic [BW-1:0] beat;
   logic [14:0] baddr;
   logic [WW-1:0] wait_cnt;
   logic idle, frc, last;
   always_comb begin
      idle = state == IDLE;
      frc = dma_req && wait_cnt == WW'(MAX_WAIT);
      last = beat == BW'(BURST - 1);
      cpu_gnt = !reset && idle && cpu_req && !frc;
      dma_gnt = !reset && idle && dma_req && !(cpu_req && !frc);
      mem_load = cpu_gnt && cpu_we;
      mem_in = cpu_gnt ? cpu_wdata : 16'h0;
      mem_address = !idle ? baddr : cpu_gnt ? cpu_addr : dma_gnt ? dma_addr : 15'h0;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         beat <= '0;
         baddr <= '0;
         wait_cnt <= '0;
         cpu_rdata <= '0;
         cpu_rvalid <= 1'b0;
         dma_rdata <= '0;
         dma_rvalid <= 1'b0;
         dma_done <= 1'b0;
      end else begin
         cpu_rvalid <= cpu_gnt && !cpu_we;
         if (cpu_gnt && !cpu_we) cpu_rdata <= mem_out;
         dma_rvalid <= dma_gnt || !idle;
         if (dma_gnt || !idle) dma_rdata <= mem_out;
         dma_done <= !idle && last;
         if (dma_gnt) begin
            state <= BRST;
            beat <= BW'(1);
            baddr <= dma_addr + 15'd1;
         end else if (!idle) begin
            baddr <= baddr + 15'd1;
            beat <= last ? '0 : beat + 1'b1;
            if (last) state <= IDLE;
         end
         // refusals only count while arbitrating; a burst in flight holds the count
         wait_cnt <= (!dma_req || dma_gnt) ? '0 :
                     (idle && wait_cnt != WW'(MAX_WAIT)) ? wait_cnt + 1'b1 : wait_cnt;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter, checked every cycle against a behavioural model plus literal expectations.
module tb_mem_arbiter;
   localparam int MAX_WAIT = 4;
   localparam int BURST = 8;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0;
   logic [14:0] cpu_addr = '0, dma_addr = '0;
   logic [15:0] cpu_wdata = '0;
   logic cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, dma_done, mem_load;
   logic [15:0] cpu_rdata, dma_rdata, mem_in, mem_out;
   logic [14:0] mem_address;
   logic [15:0] ram [0:32767];
   logic [15:0] ref_mem [0:32767];
   bit ram_ready = 1'b0;
   bit ref_ready = 1'b0;
   int n_cmp = 0, n_bad = 0;

   mem_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST(BURST)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(dma_gnt),
      .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid), .dma_done(dma_done),
      .mem_in(mem_in), .mem_load(mem_load), .mem_address(mem_address), .mem_out(mem_out)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] pat(input int a);
      return 16'(a * 37 + 'h5a5a);
   endfunction

   assign mem_out = ram[mem_address];
   always @(posedge clock) begin
      if (!ram_ready) begin
         for (int i = 0; i < 32768; i++) ram[i] <= pat(i);
         ram_ready <= 1'b1;
      end else if (mem_load) ram[mem_address] <= mem_in;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
      end
   endtask

   // Model: burst progress is a count of remaining beats; reads come from a shadow memory.
   logic [15:0] e_crd = '0, e_drd = '0;
   logic e_crv = 1'b0, e_drv = 1'b0, e_done = 1'b0;
   int left = 0, waits = 0;
   logic [14:0] m_baddr = '0;
   always @(negedge clock) begin : cmp
      logic e_cg, e_dg, e_ld, frc, was_idle;
      logic [14:0] e_addr;
      if (!ref_ready) begin
         for (int i = 0; i < 32768; i++) ref_mem[i] = pat(i);
         ref_ready = 1'b1;
      end
      chk("m_cpu_rvalid", cpu_rvalid, e_crv);
      if (e_crv) chk("m_cpu_rdata", cpu_rdata, e_crd);
      chk("m_dma_rvalid", dma_rvalid, e_drv);
      if (e_drv) chk("m_dma_rdata", dma_rdata, e_drd);
      chk("m_dma_done", dma_done, e_done);
      was_idle = left == 0;
      frc = dma_req && waits == MAX_WAIT;
      e_cg = !reset && was_idle && cpu_req && !frc;
      e_dg = !reset && was_idle && dma_req && !e_cg;
      e_ld = e_cg && cpu_we;
      e_addr = !was_idle ? m_baddr : e_cg ? cpu_addr : e_dg ? dma_addr : 15'h0;
      chk("m_cpu_gnt", cpu_gnt, e_cg);
      chk("m_dma_gnt", dma_gnt, e_dg);
      chk("m_mem_load", mem_load, e_ld);
      if (!reset) chk("m_mem_address", mem_address, e_addr);
      if (e_ld) chk("m_mem_in", mem_in, cpu_wdata);
      if (reset) begin
         e_crv = 1'b0; e_crd = '0; e_drv = 1'b0; e_drd = '0; e_done = 1'b0;
         left = 0; waits = 0; m_baddr = '0;
      end else begin
         e_crv = e_cg && !cpu_we;
         if (e_crv) e_crd = ref_mem[cpu_addr];
         e_drv = 1'b0;
         e_done = 1'b0;
         if (!was_idle) begin
            e_drv = 1'b1;
            e_drd = ref_mem[m_baddr];
            e_done = left == 1;
            m_baddr = m_baddr + 15'd1;
            left--;
         end else if (e_dg) begin
            e_drv = 1'b1;
            e_drd = ref_mem[dma_addr];
            m_baddr = dma_addr + 15'd1;
            left = BURST - 1;
         end
         if (e_ld) ref_mem[cpu_addr] = cpu_wdata;
         waits = (!dma_req || e_dg) ? 0 : (was_idle && waits < MAX_WAIT) ? waits + 1 : waits;
      end
   end

   task automatic set(input logic r, input logic cr, input logic cw, input logic [14:0] ca,
                      input logic [15:0] cd, input logic dr, input logic [14:0] da);
      reset = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd; dma_req = dr; dma_addr = da;
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   initial begin
      int rv_cnt, done_at, bad_cnt;
      logic [15:0] done_rd;
      logic [14:0] w;
      set(1, 1, 1, 15'h10, 16'hffff, 1, 15'h0);
      #2;
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_dma_gnt", dma_gnt, 0);
      chk("rst_mem_load", mem_load, 0);
      tick;
      tick;
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_dma_rvalid", dma_rvalid, 0);
      chk("rst_dma_done", dma_done, 0);
      set(0, 1, 1, 15'h10, 16'h1234, 0, 15'h0);
      #2;
      chk("wr_cpu_gnt", cpu_gnt, 1);
      chk("wr_mem_load", mem_load, 1);
      chk("wr_mem_address", mem_address, 15'h10);
      tick;
      chk("wr_no_rvalid", cpu_rvalid, 0);
      set(0, 1, 0, 15'h10, 16'h0, 0, 15'h0);
      tick;
      chk("rd_cpu_rvalid", cpu_rvalid, 1);
      chk("rd_cpu_rdata", cpu_rdata, 16'h1234);
      set(0, 0, 0, 15'h0, 16'h0, 1, 15'h4000);
      #2;
      chk("lone_dma_gnt", dma_gnt, 1);
      chk("lone_addr0", mem_address, 15'h4000);
      tick;
      rv_cnt = int'(dma_rvalid);
      done_at = dma_done ? 0 : -1;
      done_rd = '0;
      for (int k = 1; k <= 8; k++) begin
         set(0, 0, 0, 15'h0, 16'h0, 0, 15'h0);
         #2;
         if (k < 8) chk("lone_addr", mem_address, 32'h4000 + k);
         tick;
         rv_cnt += int'(dma_rvalid);
         if (dma_done) begin
            done_at = k;
            done_rd = dma_rdata;
         end
      end
      chk("lone_rvalid_cnt", rv_cnt, 8);
      chk("lone_done_at", done_at, 7);
      chk("lone_last_rdata", done_rd, pat('h4007));
      for (int i = 0; i < 14; i++) begin
         set(0, 1, 0, 15'h20, 16'h0, 1, 15'h100);
         #2;
         chk("starve_cpu_gnt", cpu_gnt, (i < 4 || i >= 12));
         chk("starve_dma_gnt", dma_gnt, (i == 4));
         tick;
      end
      set(0, 0, 0, 15'h0, 16'h0, 0, 15'h0);
      tick;
      for (int i = 0; i < 9; i++) begin
         set(0, 1, 0, 15'h30, 16'h0, i != 3, 15'h180);
         #2;
         chk("drop_dma_gnt", dma_gnt, (i == 8));
         chk("drop_cpu_gnt", cpu_gnt, (i != 8));
         tick;
      end
      for (int i = 0; i < 8; i++) begin
         set(0, 0, 0, 15'h0, 16'h0, 0, 15'h0);
         tick;
      end
      for (int i = 0; i < 9; i++) begin
         set(0, 0, 0, 15'h0, 16'h0, i == 0, 15'h7ffe);
         w = 15'h7ffe + 15'(i);
         #2;
         if (i < 4) chk("wrap_addr", mem_address, w);
         tick;
      end
      for (int i = 0; i < 17; i++) begin
         set(0, 0, 0, 15'h0, 16'h0, 1, 15'h300);
         #2;
         chk("b2b_dma_gnt", dma_gnt, (i == 0 || i == 8 || i == 16));
         tick;
      end
      for (int i = 0; i < 9; i++) begin
         set(0, 1, 1, 15'h6500, 16'hbeef, 0, 15'h0);
         tick;
      end
      set(0, 1, 0, 15'h6500, 16'h0, 0, 15'h0);
      tick;
      set(0, 0, 0, 15'h0, 16'h0, 1, 15'h200);
      tick;
      set(0, 0, 0, 15'h0, 16'h0, 0, 15'h0);
      tick;
      tick;
      set(1, 0, 0, 15'h0, 16'h0, 0, 15'h0);
      tick;
      chk("midrst_dma_rvalid", dma_rvalid, 0);
      chk("midrst_dma_done", dma_done, 0);
      bad_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         set(0, 0, 0, 15'h0, 16'h0, 0, 15'h0);
         tick;
         bad_cnt += int'(dma_rvalid) + int'(dma_done);
      end
      chk("midrst_no_stray", bad_cnt, 0);
      set(0, 0, 0, 15'h0, 16'h0, 1, 15'h55);
      #2;
      chk("fresh_dma_gnt", dma_gnt, 1);
      chk("fresh_addr", mem_address, 15'h55);
      tick;
      chk("fresh_rvalid", dma_rvalid, 1);
      chk("fresh_rdata", dma_rdata, pat('h55));
      for (int i = 0; i < 9; i++) begin
         set(0, 0, 0, 15'h0, 16'h0, 0, 15'h0);
         tick;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
